// File: rtl/pwm_capture_if.sv
// Signal bundle between the PWM input pin, the capture block and the control logic.
// The master drives the pin; the slave (pwm_capture) reports the measurements.
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 20
);
  logic             pwm_in;
  logic [CNT_W-1:0] pulse_width;
  logic [CNT_W-1:0] period;
  logic             sample_valid;
  logic             range_err;
  logic             timeout;

  modport master (
    output pwm_in,
    input  pulse_width,
    input  period,
    input  sample_valid,
    input  range_err,
    input  timeout
  );

  modport slave (
    input  pwm_in,
    output pulse_width,
    output period,
    output sample_valid,
    output range_err,
    output timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM decoder: measures high time and rising-to-rising period in clock cycles, validates the
// width against a servo window and flags loss of signal.
module pwm_capture #(
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned MIN_WIDTH = 12000,
  parameter int unsigned MAX_WIDTH = 24000,
  parameter int unsigned TIMEOUT   = 480000
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MinVal     = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MaxVal     = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] OneVal     = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] pw_q, pw_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             sv_q, sv_d;
  logic             re_q, re_d;
  logic             to_q, to_d;
  logic             s1_q, s2_q, s3_q;

  logic             rise, fall;
  logic             p_at_limit;
  logic             h_ok;
  logic [CNT_W-1:0] p_inc;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;
  assign p_at_limit = (p_q == TimeoutVal);
  assign p_inc      = p_at_limit ? p_q : p_q + OneVal;
  assign h_ok       = (h_q >= MinVal) && (h_q <= MaxVal);

  always_comb begin
    state_d = state_q;
    p_d     = p_inc;
    h_d     = h_q;
    pw_d    = pw_q;
    per_d   = per_q;
    sv_d    = 1'b0;
    re_d    = 1'b0;
    to_d    = to_q;

    case (state_q)
      StIdle: begin
        // The first rise only arms the block; nothing is measured yet.
        if (rise) begin
          state_d = StHigh;
          p_d     = OneVal;
        end else if (p_at_limit) begin
          to_d = 1'b1;
        end
      end

      StHigh: begin
        if (p_at_limit) begin
          state_d = StIdle;
          to_d    = 1'b1;
          p_d     = '0;
        end else if (fall) begin
          state_d = StLow;
          h_d     = p_q;
        end
      end

      StLow: begin
        if (rise) begin
          if (h_ok) begin
            pw_d  = h_q;
            per_d = p_q;
            sv_d  = 1'b1;
            to_d  = 1'b0;
          end else begin
            re_d = 1'b1;
          end
          state_d = StHigh;
          p_d     = OneVal;
        end else if (p_at_limit) begin
          state_d = StIdle;
          to_d    = 1'b1;
          p_d     = '0;
        end
      end

      default: begin
        state_d = StIdle;
        p_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      p_q     <= '0;
      h_q     <= '0;
      pw_q    <= '0;
      per_q   <= '0;
      sv_q    <= 1'b0;
      re_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      h_q     <= h_d;
      pw_q    <= pw_d;
      per_q   <= per_d;
      sv_q    <= sv_d;
      re_q    <= re_d;
      to_q    <= to_d;
    end
  end

  assign bus.pulse_width  = pw_q;
  assign bus.period       = per_q;
  assign bus.sample_valid = sv_q;
  assign bus.range_err    = re_q;
  assign bus.timeout      = to_q;

endmodule
